// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_e;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_rx_entry_t;

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// First-word fall-through FIFO; a write when full is accepted only alongside a read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_wr, do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync + glitch filter, frame FSM with watchdog, scancode FIFO.
// Define PS2_BREAK_DECODE_EN to fold F0/E0 prefixes into per-entry break/ext flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                            clk_cpu,
    input  logic                            rst_n,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic [7:0]                      rx_data,
    output logic                            rx_break,
    output logic                            rx_ext,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            overflow
);
    localparam int FCW = $clog2(FILTER_LEN);
    localparam int WDW = $clog2(TIMEOUT_CYC+1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int ENTRY_W = $bits(ps2_rx_entry_t);
`else
    localparam int ENTRY_W = 8;
`endif

    // Bit 0 = ps2_clk, bit 1 = ps2_data
    logic [1:0]           s1, s2, filt;
    logic [1:0][FCW-1:0]  fcnt;
    logic                 clk_q, fall, dat;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '1;
            s2    <= '1;
            filt  <= '1;
            fcnt  <= '0;
            clk_q <= 1'b1;
        end else begin
            s1    <= {ps2_data, ps2_clk};
            s2    <= s1;
            clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILTER_LEN-1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_q && !filt[0];
    assign dat  = filt[1];

    ps2_rx_state_e        state;
    logic [2:0]           bitcnt;
    logic [7:0]           shreg;
    logic                 ok;
    logic [WDW-1:0]       wdog;
    logic                 timeout, good_stop, push, pop, full, empty;
    logic                 frame_bad, par_bad;
    logic [ENTRY_W-1:0]   wr_data, rd_data;

    assign timeout   = (state != IDLE) && !fall && (wdog == WDW'(TIMEOUT_CYC-1));
    assign good_stop = fall && (state == STOP) && dat && ok;
    assign frame_bad = (fall && (state == IDLE) && dat) || (fall && (state == STOP) && !dat) || timeout;
    assign par_bad   = fall && (state == STOP) && dat && !ok;
    assign pop       = rx_valid && rx_ready;

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            ok         <= 1'b0;
            wdog       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= frame_bad;
            parity_err <= par_bad;
            overflow   <= push && full && !pop;
            wdog       <= (state == IDLE || fall) ? '0 : wdog + 1'b1;
            if (timeout) begin
                state <= IDLE;
                shreg <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: if (!dat) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                    DATA: begin
                        shreg  <= {dat, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        ok    <= dat ^ (^shreg);
                        state <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic          pend_brk, pend_ext, is_prefix;
    ps2_rx_entry_t head;

    assign is_prefix = (shreg == PS2_BREAK_CODE) || (shreg == PS2_EXT_CODE);
    assign push      = good_stop && !is_prefix;
    assign wr_data   = '{code: shreg, brk: pend_brk, ext: pend_ext};
    assign head      = rd_data;
    assign rx_data   = head.code;
    assign rx_break  = head.brk;
    assign rx_ext    = head.ext;

    // Prefix flags survive only across clean frames; any error drops them.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
        end else if (frame_bad || par_bad) begin
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
        end else if (good_stop) begin
            if (shreg == PS2_BREAK_CODE) begin
                pend_brk <= 1'b1;
            end else if (shreg == PS2_EXT_CODE) begin
                pend_ext <= 1'b1;
            end else begin
                pend_brk <= 1'b0;
                pend_ext <= 1'b0;
            end
        end
    end
`else
    assign push     = good_stop;
    assign wr_data  = shreg;
    assign rx_data  = rd_data;
    assign rx_break = 1'b0;
    assign rx_ext   = 1'b0;
`endif

    assign rx_valid = !empty;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_cpu),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_data),
        .rd_en   (rx_ready),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: serial frames in, scoreboard-checked scancodes out.
module tb_ps2_rx_fifo;
    localparam int FLEN = 8;
    localparam int DEPTH = 8;
    localparam int TMO = 1000;

    logic       clk_cpu = 1'b0;
    logic       rst_n, ps2_clk, ps2_data, rx_ready;
    logic [7:0] rx_data;
    logic       rx_break, rx_ext, rx_valid, parity_err, frame_err, overflow;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    int n_cmp = 0, n_err = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0, n_pop = 0;
    int lat;
    logic [9:0] sb[$];

    ps2_rx_fifo #(.FILTER_LEN(FLEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_break(rx_break), .rx_ext(rx_ext), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    // Pulse counting and scoreboard pops, sampled on the falling edge.
    always @(negedge clk_cpu) begin
        if (rst_n) begin
            if (parity_err) n_par++;
            if (frame_err)  n_frm++;
            if (overflow)   n_ovf++;
            if (parity_err || frame_err || overflow)
                check("pulse_onehot", 32'($onehot0({parity_err, frame_err, overflow})), 32'd1);
            if (rx_valid && rx_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("pop_entry", {22'd0, rx_data, rx_break, rx_ext}, {22'd0, sb.pop_front()});
                n_pop++;
            end
        end
    end

    // One frame, LSB first; pop_at raises rx_ready for the single cycle of that stop-low step.
    task automatic send(input logic [7:0] d, input bit bad_par, input int hp, input bit glitch,
                        input int pop_at, input int nbits, output int lat_o);
        logic [10:0] bits;
        bits  = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        lat_o = 0;
        for (int b = 0; b < nbits; b++) begin
            ps2_data = bits[b];
            for (int i = 0; i < hp; i++) begin
                step();
                if (glitch && i == hp/2) ps2_clk = 1'b0;
                if (glitch && i == hp/2 + 3) ps2_clk = 1'b1;
            end
            ps2_clk = 1'b0;
            for (int i = 1; i <= hp; i++) begin
                step();
                if (b == 10) begin
                    if (lat_o == 0 && rx_valid) lat_o = i;
                    if (i == pop_at) rx_ready = 1'b1;
                    else if (pop_at != 0 && i == pop_at + 1) rx_ready = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (hp) step();
    endtask

    task automatic drain(input int n);
        int tgt;
        tgt = n_pop + n;
        rx_ready = 1'b1;
        for (int i = 0; i < n * 4 + 10 && n_pop < tgt; i++) step();
        rx_ready = 1'b0;
        check("drain_pops", 32'(n_pop), 32'(tgt));
    endtask

    task automatic clr();
        n_par = 0; n_frm = 0; n_ovf = 0;
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rx_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_flags", {29'd0, rx_break, rx_ext, 1'b0}, 0);
        check("rst_pulses", {29'd0, parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        repeat (5) step();

        // Good frame, slow clock, exact write latency from the raw stop-bit fall
        clr();
        sb.push_back({8'h1C, 2'b00});
        send(8'h1C, 0, 200, 0, 0, 11, lat);
        check("latency", 32'(lat), 32'(FLEN + 3));
        check("count_1", 32'(fifo_count), 1);
        check("valid_1", 32'(rx_valid), 1);
        drain(1);
        check("valid_after_pop", 32'(rx_valid), 0);
        check("errs_1", 32'(n_par + n_frm + n_ovf), 0);

        // Bad parity
        clr();
        send(8'h1C, 1, 40, 0, 0, 11, lat);
        check("par_count", 32'(fifo_count), 0);
        check("par_pulses", 32'(n_par), 1);
        check("par_other", 32'(n_frm + n_ovf), 0);

        // Short low glitches on ps2_clk must be filtered out
        clr();
        sb.push_back({8'h5A, 2'b00});
        send(8'h5A, 0, 40, 1, 0, 11, lat);
        check("glitch_count", 32'(fifo_count), 1);
        check("glitch_errs", 32'(n_par + n_frm + n_ovf), 0);
        drain(1);

        // Stalled partial frame aborted by the watchdog, then recovery
        clr();
        send(8'h00, 0, 40, 0, 0, 4, lat);
        for (int i = 0; i < 2 * TMO && n_frm == 0; i++) step();
        check("wdog_frame_err", 32'(n_frm), 1);
        check("wdog_count", 32'(fifo_count), 0);
        clr();
        sb.push_back({8'h29, 2'b00});
        send(8'h29, 0, 40, 0, 0, 11, lat);
        check("recover_count", 32'(fifo_count), 1);
        check("recover_errs", 32'(n_par + n_frm + n_ovf), 0);
        drain(1);

        // Overflow: ninth frame dropped while full
        clr();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) sb.push_back({8'(k), 2'b00});
            send(8'(k), 0, 40, 0, 0, 11, lat);
        end
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_pulses", 32'(n_ovf), 1);
        drain(8);
        check("ovf_empty", 32'(rx_valid), 0);

        // Push and pop in the same cycle while full
        clr();
        for (int k = 1; k <= 9; k++) begin
            sb.push_back({8'(8'h10 + k), 2'b00});
            send(8'(8'h10 + k), 0, 40, 0, (k == 9) ? FLEN + 2 : 0, 11, lat);
        end
        check("full_pp_count", 32'(fifo_count), 8);
        check("full_pp_ovf", 32'(n_ovf), 0);
        drain(8);

        // Prefix bytes
        clr();
`ifdef PS2_BREAK_DECODE_EN
        sb.push_back({8'h74, 2'b11});
`else
        sb.push_back({8'hE0, 2'b00});
        sb.push_back({8'hF0, 2'b00});
        sb.push_back({8'h74, 2'b00});
`endif
        send(8'hE0, 0, 40, 0, 0, 11, lat);
        send(8'hF0, 0, 40, 0, 0, 11, lat);
        send(8'h74, 0, 40, 0, 0, 11, lat);
`ifdef PS2_BREAK_DECODE_EN
        check("prefix_count", 32'(fifo_count), 1);
        drain(1);
`else
        check("prefix_count", 32'(fifo_count), 3);
        drain(3);
`endif
        check("sb_drained", 32'(sb.size()), 0);
        check("final_errs", 32'(n_par + n_frm + n_ovf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
